// File: rtl/div_seg_scheduler.sv
// div_seg_scheduler: round-robin sharing of one pipelined signed divider.
// Optional divide-by-zero override when DIV_SEG_DZ_CHECK_EN is defined.
module div_seg_scheduler #(
  parameter int WIDTH      = 32,
  parameter int N_REQ      = 4,
  parameter int LAT        = 33,
  parameter int FIFO_DEPTH = 8,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_num,
  input  logic [N_REQ*WIDTH-1:0] req_den,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_num,
  output logic [WIDTH-1:0]       div_den,
  input  logic                   div_done,
  input  logic [WIDTH-1:0]       div_coc,
  input  logic [WIDTH-1:0]       div_res,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_coc,
  output logic [WIDTH-1:0]       rsp_res,
  output logic                   rsp_dz,
  output logic                   err_sync
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic             v;
    logic [IDW-1:0]   id;
`ifdef DIV_SEG_DZ_CHECK_EN
    logic             dz;
    logic [WIDTH-1:0] num;
`endif
  } tag_t;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] coc;
    logic [WIDTH-1:0] res;
    logic             dz;
  } ent_t;

  logic [IDW-1:0]   rr, gidx, id_q;
  logic             gany, hs, wr, pop;
  logic [PW:0]      in_fl, wp, rp, cnt, credits;
  logic [PW:0]      wp_n, rp_n;
  logic [WIDTH-1:0] nsel, dsel;
  tag_t             t0;
  tag_t             tag [LAT];
  ent_t             mem [FIFO_DEPTH];
  ent_t             wdat, head;
`ifdef DIV_SEG_DZ_CHECK_EN
  logic             dz_q;
`endif

  function automatic logic [IDW-1:0] wrap(input int x);
    return IDW'((x >= N_REQ) ? x - N_REQ : x);
  endfunction

  always_comb begin
    gany = 1'b0;
    gidx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gany && req_valid[wrap(int'(rr) + k)]) begin
        gany = 1'b1;
        gidx = wrap(int'(rr) + k);
      end
    end
  end

  // credits count in-flight ops plus stored responses against FIFO space
  assign cnt       = wp - rp;
  assign credits   = DEPTH - in_fl - cnt;
  assign hs        = RSTa && gany && (credits != '0);
  assign req_ready = hs ? (N_REQ'(1) << gidx) : '0;
  assign nsel      = req_num[gidx*WIDTH +: WIDTH];
  assign dsel      = req_den[gidx*WIDTH +: WIDTH];

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      rr        <= '0;
      div_start <= 1'b0;
      div_num   <= '0;
      div_den   <= '0;
      id_q      <= '0;
`ifdef DIV_SEG_DZ_CHECK_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      div_start <= hs;
      if (hs) begin
        rr      <= wrap(int'(gidx) + 1);
        div_num <= nsel;
        div_den <= dsel;
        id_q    <= gidx;
`ifdef DIV_SEG_DZ_CHECK_EN
        dz_q    <= (dsel == '0);
`endif
      end
    end
  end

  always_comb begin
    t0    = '0;
    t0.v  = div_start;
    t0.id = id_q;
`ifdef DIV_SEG_DZ_CHECK_EN
    t0.dz  = dz_q;
    t0.num = div_num;
`endif
  end

  // tag enters behind the issue register so its tail lines up with div_done
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      for (int i = 0; i < LAT; i++) tag[i] <= '0;
    end else begin
      tag[0] <= t0;
      for (int i = 1; i < LAT; i++) tag[i] <= tag[i-1];
    end
  end

  assign wr = tag[LAT-1].v;

  always_comb begin
    wdat     = '0;
    wdat.id  = tag[LAT-1].id;
    wdat.coc = div_coc;
    wdat.res = div_res;
`ifdef DIV_SEG_DZ_CHECK_EN
    if (tag[LAT-1].dz) begin
      wdat.coc = '1;
      wdat.res = tag[LAT-1].num;
      wdat.dz  = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      in_fl    <= '0;
      err_sync <= 1'b0;
    end else begin
      err_sync <= err_sync | (div_done ^ wr);
      unique case (1'b1)
        hs && !wr: in_fl <= in_fl + 1'b1;
        wr && !hs: in_fl <= in_fl - 1'b1;
        default:   in_fl <= in_fl;
      endcase
    end
  end

  assign pop  = rsp_valid && rsp_ready;
  assign wp_n = wp + (PW+1)'(wr);
  assign rp_n = rp + (PW+1)'(pop);

  always_ff @(posedge CLK) begin
    if (wr) mem[wp[PW-1:0]] <= wdat;
  end

  // show-ahead head register; bypass when the write becomes the new head
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      wp        <= '0;
      rp        <= '0;
      rsp_valid <= 1'b0;
      head      <= '0;
    end else begin
      wp        <= wp_n;
      rp        <= rp_n;
      rsp_valid <= (wp_n != rp_n);
      if (wp_n != rp_n) begin
        head <= (wr && wp == rp_n) ? wdat : mem[rp_n[PW-1:0]];
      end
    end
  end

  assign rsp_id  = head.id;
  assign rsp_coc = head.coc;
  assign rsp_res = head.res;
  assign rsp_dz  = head.dz;

endmodule

// File: doc/div_seg_scheduler.md
# div_seg_scheduler

Shares one pipelined signed divider (fixed latency, one operation accepted per cycle) among `N_REQ` requesters. Each cycle it grants at most one request by round-robin, issues the operands to the divider, and carries the requester ID through a tag pipeline matched to the divider latency. Results are collected into a credit-protected response FIFO, so the divider never produces a result that has no storage slot. The block sits between client engines and the divider core and is the only driver of the divider's `Start`, `Num` and `Den` inputs.

## Interface
- `WIDTH`, 32: operand and result width (two's complement).
- `N_REQ`, 4: number of requesters, 1..8.
- `LAT`, 33: cycles from `div_start` high to the matching `div_done` high.
- `FIFO_DEPTH`, 8: response FIFO entries, power of two, ≥2.
- `CLK` in 1: clock, rising edge.
- `RSTa` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: request pending, one bit per requester.
- `req_num` in N_REQ*WIDTH: dividends; requester i occupies slice [i*WIDTH +: WIDTH].
- `req_den` in N_REQ*WIDTH: divisors, same packing as `req_num`.
- `req_ready` out N_REQ: one-hot grant, combinational; a handshake occurs where valid & ready.
- `div_start` out 1: registered issue strobe to the divider.
- `div_num`, `div_den` out WIDTH: registered operands.
- `div_done` in 1: divider result valid.
- `div_coc`, `div_res` in WIDTH: divider quotient and remainder.
- `rsp_valid` out 1: head of the response FIFO is valid.
- `rsp_ready` in 1: consumer accepts the head.
- `rsp_id` out clog2(N_REQ) (min 1): requester that owns the response.
- `rsp_coc`, `rsp_res` out WIDTH: quotient and remainder.
- `rsp_dz` out 1: divide-by-zero flag (see Configuration).
- `err_sync` out 1: sticky; set when `div_done` disagrees with the tag pipeline.

## Operation
- **Credits.** `credits = FIFO_DEPTH − in_flight − fifo_count`. The block grants only when `credits > 0`. An issue consumes one credit. A pop (`rsp_valid && rsp_ready`) returns one credit. An issue and a pop in the same cycle leave `credits` unchanged.
- **Arbitration.** Round-robin pointer `rr`, reset value 0. The grant goes to the first i with `req_valid[i]`, searching from `rr` upward with wrap. After a grant to i, `rr ← (i+1) mod N_REQ`. With no grant, `rr` holds. If `credits == 0`, `req_ready` is all zero.
- **Issue.** On a handshake, the registered stage loads `div_num` and `div_den` from the granted slices and sets `div_start = 1` for exactly one cycle. It also pushes the tag {valid, id, dz, num} into stage 0 of a `LAT`-deep shift register.
- **Retire.** When tag stage `LAT−1` is valid, `div_done` must be 1 in the same cycle. The block then writes {id, coc, res, dz} into the FIFO and decrements `in_flight`.
  - If `div_done` is 1 and the tag is invalid, or the tag is valid and `div_done` is 0, `err_sync` is set. The tag's entry is still written; a `div_done` with no tag is discarded.
- **FIFO.** Pointers of clog2(FIFO_DEPTH)+1 bits wrap naturally. Full means the MSBs differ and the low bits are equal. Outputs are registered, show-ahead. The credit scheme guarantees a write never hits a full FIFO. A write into an empty FIFO appears on `rsp_*` the next cycle.
- **Reset.** `RSTa` low clears all state and discards in-flight tags and FIFO contents. Every output resets to 0: `req_ready`, `div_start`, `div_num`, `div_den`, `rsp_valid`, `rsp_id`, `rsp_coc`, `rsp_res`, `rsp_dz`, `err_sync`. The divider shares `RSTa`, so no stale `div_done` is expected after reset.

## Timing
- Handshake in cycle T gives `div_start` in T+1, `div_done` in T+1+LAT, and `rsp_valid` in T+2+LAT when the FIFO was empty.
- Peak throughput is one request per cycle, sustained only while `rsp_ready` keeps credits above zero.
- `req_ready` depends combinationally on `req_valid`, `rr` and `credits`. It has no dependency on `rsp_ready`.

## Configuration
- `DIV_SEG_DZ_CHECK_EN` defined:
  - When the granted `req_den == 0`, the tag carries `dz = 1` and the original `num`.
  - At retire, the divider output is replaced by `rsp_coc = all ones`, `rsp_res = num`, `rsp_dz = 1`.
  - The divider is still issued, so latency and ordering are unchanged.
- Not defined: `dz` and `num` are removed from the tag, the divider results pass through unmodified, and `rsp_dz` is tied to 0.

## Test plan
- Single request: requester 1 sends num=100, den=7. Expect `rsp_valid` at T+35 with `rsp_id=1`, `rsp_coc=14`, `rsp_res=2`.
- Signed operands: num=−100, den=7 gives coc=−14, res=−2. num=100, den=−7 gives coc=−14, res=2.
- Fairness: all 4 requesters hold `req_valid` continuously with `rsp_ready=1`. Grants rotate 0,1,2,3,0,…, and responses return in the same order, one per cycle.
- Backpressure: `rsp_ready=0` with all requesters active. Exactly 8 grants occur, then `req_ready` stays 0. Raising `rsp_ready` for one cycle allows exactly one new grant.
- Mid-flight reset: pull `RSTa` low while 5 operations are in flight. All outputs read 0, and no `rsp_valid` occurs after release until new requests are made.
- With `DIV_SEG_DZ_CHECK_EN`: num=55, den=0 gives `rsp_coc=32'hFFFFFFFF`, `rsp_res=55`, `rsp_dz=1`. Separately, a `div_done` pulse forced with no tag sets `err_sync`, which stays set until reset.
